single_display: RTL and testbench
=================================

# single_display

LED-matrix driver that renders the 6-bit game-state code `screen` onto a 32×16 HUB75-style RGB panel (1/8 scan, two half-panels driven in parallel). It sits downstream of the `single` state classifier and drives the panel pins directly. It generates the column shift clock, latch, output-enable and row-address sequence continuously from one system clock.

## Interface
- `HOLD_CYCLES`, default 64: clk cycles a latched row stays lit (oe low) after its latch pulse; minimum 1.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `screen`  in  6  display code from `single`; bit 5 is the leftmost bar.
- `rgb`  out  6  pixel data `{r1,g1,b1,r2,g2,b2}`; `r1g1b1` is the upper half (rows 0–7), `r2g2b2` is the lower half (rows 8–15).
- `lat`  out  1  latch strobe, active high.
- `oe`  out  1  output enable, active low (1 = panel blanked).
- `abc`  out  3  row-pair address: `{c,b,a}` = row r, which selects panel rows r and r+8.
- `outclk`  out  1  column shift clock; the panel samples `rgb` on its rising edge.

## Operation
- Image definition:
  - Columns 4i..4i+3 (i = 0..5) form bar i, which is controlled by `screen[5-i]`.
  - Bit = 1: all six rgb bits are 1 (white) for both halves.
  - Bit = 0: rgb = 0.
  - Columns 24–31 are always 0.
  - Every row shows the same pattern.
- Frame snapshot: `screen` is registered into `screen_q` on the first cycle of the SHIFT phase for row 0. The whole frame uses `screen_q`, so there is no tearing mid-frame.
- Per-row FSM, with row counter r = 0..7:
  - SHIFT (64 clk): 32 columns, 2 clk each.
    - Shift index k = 0..31 selects column 31−k.
    - 1st clk of each column: outclk=0, rgb = pixel data.
    - 2nd clk of each column: outclk=1, rgb held.
    - oe=0 and abc = previous row (panel shows the previously latched row), except that oe stays 1 during the first SHIFT after reset.
  - BLANK (1 clk): oe=1, outclk=0, lat=0.
  - LATCH (1 clk): oe=1, lat=1, abc=r.
  - HOLD (HOLD_CYCLES clk): oe=0, lat=0, abc=r, outclk=0, rgb=0.
  - After HOLD: r ← (r+1) mod 8 (7 wraps to 0), then SHIFT.
- During the BLANK/LATCH/HOLD phases, rgb stays at the last shifted column's data or 0. Bench requirement: rgb=0 in HOLD.
- Counters:
  - 6-bit shift-phase counter.
  - HOLD counter sized for HOLD_CYCLES.
  - 3-bit row counter, wrap-around natural.

## Timing
- Reset (reset=0, asynchronous): rgb=0, lat=0, oe=1, abc=0, outclk=0, FSM=SHIFT, r=0, counters=0, screen_q=0. Outputs take these values immediately, without waiting for a clock edge.
- Reset release: the first rising clk edge with reset=1 starts SHIFT for row 0 and samples screen_q. No initial row is displayed until the first LATCH.
- Row period is 66 + HOLD_CYCLES clk (130 at default). Frame period is 8× the row period (1040 clk).
- outclk runs at clk/2 during SHIFT, with exactly 32 rising edges per row. outclk is low outside SHIFT.
- lat is high for exactly 1 clk per row. oe=1 throughout BLANK and LATCH, so the latch never occurs while the row is lit.
- abc changes only on the LATCH cycle.
- A `screen` change mid-frame takes effect at the next row-0 SHIFT start: latency up to 1 frame plus 1 clk.
- Reset asserted mid-row: everything aborts to the reset state. There is no partial latch; lat drops at once.

## Test plan
- Reset: hold reset=0, toggle clk → rgb=0, lat=0, oe=1, abc=0, outclk=0. Assert reset mid-SHIFT → same values before the next edge.
- screen=3 (6'b000011), default parameters → in row 0 SHIFT:
  - k=8..15 (columns 23..16) give rgb=6'b111111.
  - All other k give rgb=0.
  - Exactly 32 outclk rising edges occur, then 1 BLANK clk (oe=1), then 1 LATCH clk (lat=1, abc=0), then 64 clk with oe=0.
- screen=6'b111111 → columns 0–23 are white and 24–31 are 0. screen=0 → rgb=0 for all 32 columns.
- Row sequencing: abc takes the sequence 0,1,…,7,0 at successive lat pulses, spaced 130 clk apart. The wrap 7→0 occurs with no extra cycles.
- Snapshot: change screen from 3 to 6'b100000 during row 3 → rows 3–7 still show the screen=3 pattern. The next row 0 shows only columns 0–3 lit.
- HOLD_CYCLES=1 → row period is 67 clk, and lat/oe ordering is unchanged.

Source files
------------

// File: rtl/single_display.sv
// HUB75 1/8-scan driver: renders the 6-bar screen code onto a 32x16 panel.
// Repeating row sequence: SHIFT(64) -> BLANK(1) -> LATCH(1) -> HOLD(HOLD_CYCLES).
module single_display #(
  parameter int HOLD_CYCLES = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] screen,
  output logic [5:0] rgb,
  output logic       lat,
  output logic       oe,
  output logic [2:0] abc,
  output logic       outclk
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {ST_SHIFT, ST_BLANK, ST_LATCH, ST_HOLD} state_t;

  state_t          state_q, state_d;
  logic [5:0]      cnt_q, cnt_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [2:0]      row_q, row_d;
  logic [2:0]      abc_q, abc_d;
  logic [5:0]      screen_q, screen_d;
  logic            run_q, run_d;
  logic            first_q, first_d;

  // run_q is low only while in reset, so outputs show the reset values until the first edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_SHIFT;
      cnt_q    <= '0;
      hold_q   <= '0;
      row_q    <= '0;
      abc_q    <= '0;
      screen_q <= '0;
      run_q    <= 1'b0;
      first_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hold_q   <= hold_d;
      row_q    <= row_d;
      abc_q    <= abc_d;
      screen_q <= screen_d;
      run_q    <= run_d;
      first_q  <= first_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hold_d   = hold_q;
    row_d    = row_q;
    abc_d    = abc_q;
    screen_d = screen_q;
    run_d    = run_q;
    first_d  = first_q;
    if (!run_q) begin
      run_d    = 1'b1;
      screen_d = screen;
    end else begin
      case (state_q)
        ST_SHIFT: begin
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'd63) begin
            state_d = ST_BLANK;
            first_d = 1'b0;
          end
        end
        ST_BLANK: begin
          state_d = ST_LATCH;
          abc_d   = row_q;
        end
        ST_LATCH: begin
          state_d = ST_HOLD;
          hold_d  = '0;
        end
        default: begin
          if (hold_q == HOLD_LAST) begin
            state_d = ST_SHIFT;
            cnt_d   = '0;
            row_d   = row_q + 3'd1;
            // Frame snapshot taken as row 0 begins, so a frame never tears.
            if (row_q == 3'd7) screen_d = screen;
          end else begin
            hold_d = hold_q + HW'(1);
          end
        end
      endcase
    end
  end

  // Shift index k = cnt_q[5:1] drives column 31-k; its bar number is ~k[4:2].
  logic [7:0] bar_on;
  logic [2:0] bar_idx;
  logic       pix;

  always_comb begin
    bar_on  = {2'b00, screen_q[0], screen_q[1], screen_q[2],
               screen_q[3], screen_q[4], screen_q[5]};
    bar_idx = ~cnt_q[5:3];
    pix     = bar_on[bar_idx];
  end

  always_comb begin
    rgb    = '0;
    lat    = 1'b0;
    oe     = 1'b1;
    outclk = 1'b0;
    abc    = abc_q;
    if (run_q) begin
      case (state_q)
        ST_SHIFT: begin
          rgb    = {6{pix}};
          outclk = cnt_q[0];
          oe     = first_q;
        end
        ST_LATCH: lat = 1'b1;
        ST_HOLD:  oe  = 1'b0;
        default:  ;
      endcase
    end
  end

endmodule

// File: tb/tb_single_display.sv
// Directed bench for single_display: default HOLD instance plus a HOLD_CYCLES=1 instance.
module tb_single_display;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] screen = 6'd0;
  logic [5:0] rgb, rgb1;
  logic       lat, lat1, oe, oe1, outclk, outclk1;
  logic [2:0] abc, abc1;

  int compared   = 0;
  int mismatched = 0;

  single_display dut (
    .clk(clk), .reset(reset), .screen(screen),
    .rgb(rgb), .lat(lat), .oe(oe), .abc(abc), .outclk(outclk)
  );

  single_display #(.HOLD_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .screen(screen),
    .rgb(rgb1), .lat(lat1), .oe(oe1), .abc(abc1), .outclk(outclk1)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) step();
    compared += 5;
    if (rgb !== 6'd0)   begin mismatched++; $display("FAIL reset_rgb: got %h expected 00", rgb); end
    if (lat !== 1'b0)   begin mismatched++; $display("FAIL reset_lat: got %b expected 0", lat); end
    if (oe !== 1'b1)    begin mismatched++; $display("FAIL reset_oe: got %b expected 1", oe); end
    if (abc !== 3'd0)   begin mismatched++; $display("FAIL reset_abc: got %0d expected 0", abc); end
    if (outclk !== 1'b0) begin mismatched++; $display("FAIL reset_outclk: got %b expected 0", outclk); end
  endtask

  // Entry: 1 ns after the edge that starts cycle 0 of the row. Exit: same point of the next row.
  task automatic test_row(input int row, input logic [31:0] mask, input bit first, input int prev_abc);
    int rises = 0;
    logic prev_clk = 1'b0;
    for (int c = 0; c < 130; c++) begin
      logic [5:0] e_rgb;
      logic       e_lat, e_oe, e_clk;
      int         e_abc;
      bit         chk_rgb;
      chk_rgb = 1'b1;
      e_rgb = 6'd0; e_lat = 1'b0; e_clk = 1'b0; e_oe = 1'b0; e_abc = row;
      if (c < 64) begin
        e_rgb = mask[31 - c / 2] ? 6'h3f : 6'h00;
        e_clk = c[0];
        e_oe  = first;
        e_abc = prev_abc;
        if (outclk === 1'b1 && prev_clk === 1'b0) rises++;
        prev_clk = outclk;
      end else if (c == 64) begin
        e_oe = 1'b1; e_abc = prev_abc; chk_rgb = 1'b0;
      end else if (c == 65) begin
        e_oe = 1'b1; e_lat = 1'b1; chk_rgb = 1'b0;
      end
      compared += 4;
      if (chk_rgb) begin
        compared++;
        if (rgb !== e_rgb) begin mismatched++; $display("FAIL row%0d_c%0d_rgb: got %h expected %h", row, c, rgb, e_rgb); end
      end
      if (outclk !== e_clk) begin mismatched++; $display("FAIL row%0d_c%0d_outclk: got %b expected %b", row, c, outclk, e_clk); end
      if (lat !== e_lat) begin mismatched++; $display("FAIL row%0d_c%0d_lat: got %b expected %b", row, c, lat, e_lat); end
      if (oe !== e_oe) begin mismatched++; $display("FAIL row%0d_c%0d_oe: got %b expected %b", row, c, oe, e_oe); end
      if (abc !== 3'(e_abc)) begin mismatched++; $display("FAIL row%0d_c%0d_abc: got %0d expected %0d", row, c, abc, e_abc); end
      step();
    end
    compared++;
    if (rises != 32) begin mismatched++; $display("FAIL row%0d_outclk_rises: got %0d expected 32", row, rises); end
  endtask

  task automatic test_first_frame();
    screen = 6'b000011;
    reset = 1'b1;
    step();
    test_row(0, 32'h00FF_0000, 1'b1, 0);
    for (int r = 1; r < 8; r++) begin
      if (r == 3) screen = 6'b100000;
      test_row(r, 32'h00FF_0000, 1'b0, r - 1);
    end
  endtask

  task automatic test_snapshot();
    test_row(0, 32'h0000_000F, 1'b0, 7);
    screen = 6'b000000;
    for (int r = 1; r < 8; r++) test_row(r, 32'h0000_000F, 1'b0, r - 1);
  endtask

  task automatic test_patterns();
    test_row(0, 32'h0000_0000, 1'b0, 7);
    screen = 6'b111111;
    for (int r = 1; r < 8; r++) test_row(r, 32'h0000_0000, 1'b0, r - 1);
    test_row(0, 32'h00FF_FFFF, 1'b0, 7);
  endtask

  task automatic test_reset_mid_row();
    repeat (17) step();
    compared++;
    if (rgb !== 6'h3f || outclk !== 1'b1) begin
      mismatched++; $display("FAIL pre_reset_shift: got rgb=%h outclk=%b expected rgb=3f outclk=1", rgb, outclk);
    end
    reset = 1'b0;
    #1;
    compared += 5;
    if (rgb !== 6'd0)    begin mismatched++; $display("FAIL midreset_rgb: got %h expected 00", rgb); end
    if (lat !== 1'b0)    begin mismatched++; $display("FAIL midreset_lat: got %b expected 0", lat); end
    if (oe !== 1'b1)     begin mismatched++; $display("FAIL midreset_oe: got %b expected 1", oe); end
    if (abc !== 3'd0)    begin mismatched++; $display("FAIL midreset_abc: got %0d expected 0", abc); end
    if (outclk !== 1'b0) begin mismatched++; $display("FAIL midreset_outclk: got %b expected 0", outclk); end
    reset = 1'b1;
    step();
    repeat (65) step();
    compared++;
    if (lat !== 1'b1) begin mismatched++; $display("FAIL pre_reset_latch: got %b expected 1", lat); end
    reset = 1'b0;
    #1;
    compared += 3;
    if (lat !== 1'b0) begin mismatched++; $display("FAIL latreset_lat: got %b expected 0", lat); end
    if (oe !== 1'b1)  begin mismatched++; $display("FAIL latreset_oe: got %b expected 1", oe); end
    if (abc !== 3'd0) begin mismatched++; $display("FAIL latreset_abc: got %0d expected 0", abc); end
  endtask

  task automatic test_hold1();
    reset = 1'b1;
    step();
    for (int c = 0; c <= 140; c++) begin
      logic e_lat, e_oe;
      logic [2:0] e_abc;
      e_lat = (c == 65 || c == 132);
      e_oe  = (c <= 65 || c == 131 || c == 132);
      e_abc = (c >= 132) ? 3'd1 : 3'd0;
      compared += 3;
      if (lat1 !== e_lat) begin mismatched++; $display("FAIL hold1_c%0d_lat: got %b expected %b", c, lat1, e_lat); end
      if (oe1 !== e_oe)   begin mismatched++; $display("FAIL hold1_c%0d_oe: got %b expected %b", c, oe1, e_oe); end
      if (abc1 !== e_abc) begin mismatched++; $display("FAIL hold1_c%0d_abc: got %0d expected %0d", c, abc1, e_abc); end
      if (c == 66) begin
        compared++;
        if (rgb1 !== 6'd0) begin mismatched++; $display("FAIL hold1_hold_rgb: got %h expected 00", rgb1); end
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_snapshot();
    test_patterns();
    test_reset_mid_row();
    test_hold1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
